// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if
// Bundles the execute-stage connection to the multiply/divide sequencer.
//   master : pipeline side, drives the request, abort, mfhi/mflo and mthi/mtlo controls
//   slave  : sequencer side, drives hilo_q, busy, done and stall
// Signals:
//   start, op[1:0], src_rs, src_rt   operation request and operands
//   abort                            pipeline flush
//   hilo_rd, mthi_en, mtlo_en, mt_data   HI/LO access from the instruction in execute
//   hilo_q                           registered {HI, LO}
//   busy, done, stall                sequencer status
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic [1:0]           op;
    logic [WIDTH-1:0]     src_rs;
    logic [WIDTH-1:0]     src_rt;
    logic                 abort;
    logic                 hilo_rd;
    logic                 mthi_en;
    logic                 mtlo_en;
    logic [WIDTH-1:0]     mt_data;
    logic [2*WIDTH-1:0]   hilo_q;
    logic                 busy;
    logic                 done;
    logic                 stall;

    modport master (
        output start, op, src_rs, src_rt, abort, hilo_rd, mthi_en, mtlo_en, mt_data,
        input  hilo_q, busy, done, stall
    );

    modport slave (
        input  start, op, src_rs, src_rt, abort, hilo_rd, mthi_en, mtlo_en, mt_data,
        output hilo_q, busy, done, stall
    );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq
// Iterative MULT/MULTU/DIV/DIVU unit that owns the HI/LO register pair.
// A 32-step LSB-first shift-add multiplier and a 32-step restoring divider
// share one accumulator; a single FIXUP cycle applies signs and the
// divide-by-zero override before the result is written to HI/LO.
// Ports:
//   clk_cpu  CPU clock, rising edge
//   reset    asynchronous, active-low
//   bus      muldiv_seq_if slave modport (request, abort, HI/LO access, status)
module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic         clk_cpu,
    input  logic         reset,
    muldiv_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [CNT_W-1:0]     count_q;
    logic                 is_div_q;
    logic                 sign_q_q;
    logic                 sign_r_q;
    logic [WIDTH-1:0]     rs_raw_q;
    logic [WIDTH-1:0]     opnd_b_q;
    logic [WIDTH-1:0]     acc_hi_q;
    logic [WIDTH-1:0]     acc_lo_q;
    logic [2*WIDTH-1:0]   hilo_r;
    logic                 busy_r;
    logic                 done_r;

    logic                 start_ok;
    logic                 signed_in;
    logic [WIDTH-1:0]     rs_mag;
    logic [WIDTH-1:0]     rt_mag;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;
    logic [2*WIDTH-1:0]   product;
    logic [WIDTH-1:0]     quot_fix;
    logic [WIDTH-1:0]     rem_fix;
    logic [2*WIDTH-1:0]   fix_result;

    // Operand magnitudes; negating the most negative value yields 2^(WIDTH-1)
    // as an unsigned magnitude, which is exactly what the iterations need.
    always_comb begin
        start_ok  = bus.start & ~bus.abort;
        signed_in = ~bus.op[0];
        rs_mag    = (signed_in & bus.src_rs[WIDTH-1]) ? -bus.src_rs : bus.src_rs;
        rt_mag    = (signed_in & bus.src_rt[WIDTH-1]) ? -bus.src_rt : bus.src_rt;
    end

    // One iteration of either algorithm. Multiply keeps the running partial
    // product in acc_hi and the not-yet-consumed multiplier bits in acc_lo.
    // Divide keeps the partial remainder in acc_hi and shifts the dividend out
    // of acc_lo while the quotient bits shift in behind it.
    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_b_q} : {(WIDTH+1){1'b0}});
        div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_b_q};
    end

    // Final result: signs applied to the magnitude results, and a zero
    // divisor overrides everything with LO=all ones, HI=dividend as given.
    always_comb begin
        product    = {acc_hi_q, acc_lo_q};
        quot_fix   = sign_q_q ? -acc_lo_q : acc_lo_q;
        rem_fix    = sign_r_q ? -acc_hi_q : acc_hi_q;
        fix_result = sign_q_q ? -product : product;
        if (is_div_q) begin
            if (opnd_b_q == '0) begin
                fix_result = {rs_raw_q, {WIDTH{1'b1}}};
            end else begin
                fix_result = {rem_fix, quot_fix};
            end
        end
    end

    // Next-state logic; abort returns to IDLE from any state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (count_q == CNT_W'(WIDTH-1)) begin
                    state_d = FIXUP;
                end
            end
            FIXUP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register plus the registered busy/done status.
    always_ff @(posedge clk_cpu or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_r  <= (state_d != IDLE);
            done_r  <= (state_q == FIXUP) && !bus.abort;
        end
    end

    // Datapath: operand capture in IDLE, iterations in CALC, HI/LO write in
    // FIXUP. mthi/mtlo only land while idle, and abort does not block them.
    always_ff @(posedge clk_cpu or negedge reset) begin
        if (!reset) begin
            count_q  <= '0;
            is_div_q <= 1'b0;
            sign_q_q <= 1'b0;
            sign_r_q <= 1'b0;
            rs_raw_q <= '0;
            opnd_b_q <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            hilo_r   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        is_div_q <= bus.op[1];
                        sign_q_q <= signed_in & (bus.src_rs[WIDTH-1] ^ bus.src_rt[WIDTH-1]);
                        sign_r_q <= signed_in & bus.src_rs[WIDTH-1];
                        rs_raw_q <= bus.src_rs;
                        acc_hi_q <= '0;
                        count_q  <= '0;
                        if (bus.op[1]) begin
                            opnd_b_q <= rt_mag;
                            acc_lo_q <= rs_mag;
                        end else begin
                            opnd_b_q <= rs_mag;
                            acc_lo_q <= rt_mag;
                        end
                    end
                    if (bus.mthi_en) begin
                        hilo_r[2*WIDTH-1:WIDTH] <= bus.mt_data;
                    end
                    if (bus.mtlo_en) begin
                        hilo_r[WIDTH-1:0] <= bus.mt_data;
                    end
                end
                CALC: begin
                    if (!bus.abort) begin
                        count_q <= count_q + CNT_W'(1);
                        if (is_div_q) begin
                            acc_hi_q <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
                            acc_lo_q <= {acc_lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
                        end else begin
                            {acc_hi_q, acc_lo_q} <= {mul_sum, acc_lo_q[WIDTH-1:1]};
                        end
                    end
                end
                FIXUP: begin
                    if (!bus.abort) begin
                        hilo_r <= fix_result;
                    end
                end
                default: begin
                    count_q <= '0;
                end
            endcase
        end
    end

    assign bus.hilo_q = hilo_r;
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.stall  = busy_r & (bus.start | bus.hilo_rd | bus.mthi_en | bus.mtlo_en);

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq
// Self-checking bench for muldiv_seq: a table of operations with their
// expected {HI, LO}, run through a scoreboard queue, plus hand-written
// sequences for stall, abort and mid-operation reset behaviour.
module tb_muldiv_seq;

    localparam int WIDTH = 32;

    logic clk_cpu = 1'b0;
    logic reset;

    muldiv_seq_if #(.WIDTH(WIDTH)) bus ();

    muldiv_seq #(.WIDTH(WIDTH)) dut (
        .clk_cpu (clk_cpu),
        .reset   (reset),
        .bus     (bus)
    );

    // 10-unit clock period
    always #5 clk_cpu = ~clk_cpu;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [63:0] exp;
        string       name;
    } vec_t;

    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;

    vec_t        vecs[$];
    logic [63:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    // Compare one value against its expectation and keep the tallies.
    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add_vec(input logic [1:0] op, input logic [31:0] rs,
                                    input logic [31:0] rt, input logic [63:0] exp,
                                    input string name);
        vec_t v;
        v.op = op; v.rs = rs; v.rt = rt; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endfunction

    // Launch one operation at a negedge (cycle 0), wait for done with a cycle
    // budget, then check latency, busy, the scoreboard result and the pulse.
    task automatic apply_stimulus(input logic [1:0] op, input logic [31:0] rs,
                                  input logic [31:0] rt, input logic [63:0] exp,
                                  input string name, input bit check_busy);
        int          cyc;
        logic [63:0] want;
        @(negedge clk_cpu);
        bus.op     = op;
        bus.src_rs = rs;
        bus.src_rt = rt;
        bus.start  = 1'b1;
        exp_q.push_back(exp);
        @(negedge clk_cpu);
        bus.start = 1'b0;
        cyc = 1;
        while (!bus.done && cyc < 60) begin
            if (check_busy) check_output({name, "_busy"}, 64'(bus.busy), 64'd1);
            @(negedge clk_cpu);
            cyc++;
        end
        check_output({name, "_latency"}, 64'(cyc), 64'd34);
        check_output({name, "_busy_at_done"}, 64'(bus.busy), 64'd0);
        want = exp_q.pop_front();
        check_output({name, "_hilo"}, bus.hilo_q, want);
        @(negedge clk_cpu);
        check_output({name, "_done_pulse"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        int          cyc;
        int          stall_bad;
        int          hi_bad;
        int          done_seen;
        logic [63:0] want;
        int          abort_cycles[2];

        bus.start   = 1'b0;
        bus.op      = 2'd0;
        bus.src_rs  = '0;
        bus.src_rt  = '0;
        bus.abort   = 1'b0;
        bus.hilo_rd = 1'b0;
        bus.mthi_en = 1'b0;
        bus.mtlo_en = 1'b0;
        bus.mt_data = '0;

        add_vec(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "multu_max");
        add_vec(OP_MULT,  32'hFFFF_FFFD, 32'd7,         64'hFFFF_FFFF_FFFF_FFEB, "mult_neg3x7");
        add_vec(OP_DIV,   32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD, "div_neg7by2");
        add_vec(OP_DIVU,  32'd5,         32'd0,         64'h0000_0005_FFFF_FFFF, "divu_by0");
        add_vec(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, "div_ovf");
        add_vec(OP_DIVU,  32'd100,       32'd7,         64'h0000_0002_0000_000E, "divu_100by7");
        add_vec(OP_MULT,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "mult_minsq");
        add_vec(OP_DIV,   32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, "div_7byneg2");
        add_vec(OP_DIV,   32'hFFFF_FFF8, 32'd0,         64'hFFFF_FFF8_FFFF_FFFF, "div_by0_neg");
        add_vec(OP_MULT,  32'hFFFF_FFFF, 32'd1,         64'hFFFF_FFFF_FFFF_FFFF, "mult_neg1x1");
        add_vec(OP_DIVU,  32'hFFFF_FFFF, 32'd1,         64'h0000_0000_FFFF_FFFF, "divu_max_by1");
        add_vec(OP_MULTU, 32'd6,         32'd7,         64'h0000_0000_0000_002A, "multu_6x7");

        // Reset state, with start held high to show stall stays low when idle.
        reset = 1'b0;
        bus.start = 1'b1;
        #12;
        check_output("reset_hilo", bus.hilo_q, 64'd0);
        check_output("reset_busy", 64'(bus.busy), 64'd0);
        check_output("reset_done", 64'(bus.done), 64'd0);
        check_output("reset_stall", 64'(bus.stall), 64'd0);
        bus.start = 1'b0;
        @(negedge clk_cpu);
        reset = 1'b1;

        // Table-driven operations; the first one also checks busy cycle by cycle.
        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].exp, vecs[i].name, i == 0);
        end

        // MULT in flight with mfhi and mthi arriving: stall while busy, retry lands after done.
        @(negedge clk_cpu);
        bus.op = OP_MULT; bus.src_rs = 32'd3; bus.src_rt = 32'd5; bus.start = 1'b1;
        exp_q.push_back(64'h0000_0000_0000_000F);
        @(negedge clk_cpu);
        bus.start = 1'b0;
        cyc = 1; stall_bad = 0; hi_bad = 0;
        while (!bus.done && cyc < 60) begin
            if (cyc == 4) bus.hilo_rd = 1'b1;
            if (cyc == 5) begin
                bus.hilo_rd = 1'b0;
                bus.mthi_en = 1'b1;
                bus.mt_data = 32'h0000_1234;
            end
            #1;
            if (cyc >= 4 && bus.stall !== 1'b1) stall_bad++;
            if (bus.hilo_q[63:32] === 32'h0000_1234) hi_bad++;
            @(negedge clk_cpu);
            cyc++;
        end
        check_output("stall_while_busy", 64'(stall_bad), 64'd0);
        check_output("hi_untouched_while_busy", 64'(hi_bad), 64'd0);
        check_output("stall_latency", 64'(cyc), 64'd34);
        check_output("stall_released", 64'(bus.stall), 64'd0);
        want = exp_q.pop_front();
        check_output("stall_mult_hilo", bus.hilo_q, want);
        @(negedge clk_cpu);
        check_output("mthi_retry", bus.hilo_q, 64'h0000_1234_0000_000F);
        bus.mthi_en = 1'b0;

        // Preload HI/LO; LO is written alongside abort+start to show abort
        // blocks the start but not the mtlo write.
        bus.mthi_en = 1'b1; bus.mt_data = 32'hAAAA_AAAA;
        @(negedge clk_cpu);
        bus.mthi_en = 1'b0;
        bus.mtlo_en = 1'b1; bus.mt_data = 32'h5555_5555;
        bus.abort = 1'b1; bus.start = 1'b1; bus.op = OP_DIVU;
        @(negedge clk_cpu);
        bus.mtlo_en = 1'b0; bus.abort = 1'b0; bus.start = 1'b0;
        check_output("abort_start_idle", 64'(bus.busy), 64'd0);
        check_output("preload_hilo", bus.hilo_q, 64'hAAAA_AAAA_5555_5555);

        // Abort in CALC (cycle 10) and in FIXUP (cycle 33).
        abort_cycles[0] = 10;
        abort_cycles[1] = 33;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_cpu);
            bus.op = OP_DIVU; bus.src_rs = 32'd100; bus.src_rt = 32'd7; bus.start = 1'b1;
            @(negedge clk_cpu);
            bus.start = 1'b0;
            cyc = 1; done_seen = 0;
            while (cyc < abort_cycles[k]) begin
                if (bus.done) done_seen++;
                @(negedge clk_cpu);
                cyc++;
            end
            check_output("abort_busy_before", 64'(bus.busy), 64'd1);
            bus.abort = 1'b1;
            @(negedge clk_cpu);
            bus.abort = 1'b0;
            check_output("abort_goes_idle", 64'(bus.busy), 64'd0);
            for (int j = 0; j < 40; j++) begin
                if (bus.done) done_seen++;
                @(negedge clk_cpu);
            end
            check_output("abort_no_done", 64'(done_seen), 64'd0);
            check_output("abort_hilo_kept", bus.hilo_q, 64'hAAAA_AAAA_5555_5555);
        end

        // Reset pulled mid-operation clears HI/LO at once; a fresh op then works.
        @(negedge clk_cpu);
        bus.op = OP_MULTU; bus.src_rs = 32'hFFFF_FFFF; bus.src_rt = 32'hFFFF_FFFF; bus.start = 1'b1;
        @(negedge clk_cpu);
        bus.start = 1'b0;
        for (int j = 1; j < 20; j++) @(negedge clk_cpu);
        reset = 1'b0;
        #1;
        check_output("midop_reset_hilo", bus.hilo_q, 64'd0);
        check_output("midop_reset_busy", 64'(bus.busy), 64'd0);
        check_output("midop_reset_done", 64'(bus.done), 64'd0);
        @(negedge clk_cpu);
        reset = 1'b1;
        apply_stimulus(OP_MULTU, 32'd6, 32'd7, 64'h0000_0000_0000_002A, "after_reset_6x7", 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle sequencer for MULT/MULTU/DIV/DIVU and owner of the HI/LO register pair. Replaces the single-cycle `*`, `/` and `%` paths with an iterative 32-step shift-add multiplier and restoring divider. It sits beside the ALU in the execute stage:
- It accepts an operation from decode.
- It holds the pipeline via `stall` while an operation is in flight and a dependent instruction arrives.
- It presents HI/LO to the ALU for mfhi/mflo.

## Interface
Parameters:
- WIDTH, 32: operand width. HI/LO together are 2*WIDTH bits.
- CNT_W, $clog2(WIDTH): width of the iteration counter.

Ports:
- clk_cpu  in  1  CPU clock; all state updates on the rising edge.
- reset  in  1  Asynchronous, active-low reset.
- start  in  1  Request a new operation; sampled only in IDLE.
- op  in  2  Operation select: 0=MULT, 1=MULTU, 2=DIV, 3=DIVU. Sampled with `start`.
- src_rs  in  WIDTH  rs operand. Multiplicand or dividend.
- src_rt  in  WIDTH  rt operand. Multiplier or divisor.
- abort  in  1  Pipeline flush. Cancels any in-flight operation.
- hilo_rd  in  1  The instruction in execute reads HI or LO (mfhi/mflo).
- mthi_en  in  1  Write `mt_data` to HI.
- mtlo_en  in  1  Write `mt_data` to LO.
- mt_data  in  WIDTH  Data for mthi/mtlo.
- hilo_q  out  2*WIDTH  Registered {HI, LO}.
- busy  out  1  Registered. High in CALC and FIXUP.
- done  out  1  Registered one-cycle pulse. High in the first cycle `hilo_q` shows a completed result.
- stall  out  1  Combinational: busy & (start | hilo_rd | mthi_en | mtlo_en).

## Operation
- States: IDLE, CALC, FIXUP.

IDLE:
- start & ~abort: latch operand magnitudes and sign flags, clear the accumulator, set count=0, go to CALC.
- Operand magnitudes for signed ops are the absolute values of the operands. 0x8000_0000 is treated as unsigned 2^31.
- Signed ops also record sign_q = rs[31]^rt[31] and sign_r = rs[31].

CALC:
- One iteration per cycle, WIDTH cycles total (count 0..WIDTH-1), then go to FIXUP.
- Multiply: shift-add, LSB-first over the multiplier. Produces a 2*WIDTH unsigned product.
- Divide: restoring, MSB-first over the dividend. Produces a WIDTH quotient and a WIDTH remainder.

FIXUP (1 cycle):
- Signed multiply with sign_q=1: negate the 64-bit product.
- Signed divide: negate the quotient if sign_q=1; negate the remainder if sign_r=1.
- Divisor == 0 (DIV or DIVU), overriding the above: LO=0xFFFF_FFFF, HI=src_rs as latched. No exception is raised.
- Signed overflow 0x8000_0000 / 0xFFFF_FFFF: LO=0x8000_0000, HI=0. This falls out of the magnitude path.
- Result written {HI, LO} at the closing edge of the cycle. Next state is IDLE, done=1.

Product/division write mapping:
- Multiply: HI = product[63:32], LO = product[31:0].
- Divide: HI = remainder, LO = quotient.

mthi/mtlo:
- Applied at the edge only when not busy. Each enable writes its half independently.
- While busy, the write is ignored and `stall` is raised; the pipeline holds the instruction until it retries.

start while busy:
- Ignored, and `stall` is raised.
- The new op is accepted at the first IDLE cycle where `start` is still high.

abort:
- Highest priority. Any state goes to IDLE at the next edge.
- HI/LO stay unchanged, done=0.
- abort in FIXUP suppresses the write.
- abort together with start in IDLE: start is ignored.
- abort does not block mthi/mtlo writes in IDLE.

Simultaneous events in IDLE:
- start and mthi/mtlo in the same cycle: both take effect. The operation result later overwrites HI/LO.

## Timing
- Reset values (asynchronous, while reset=0): state=IDLE, hilo_q=0, busy=0, done=0, count=0. `stall` is then 0.
- Latency: with start sampled at the edge ending cycle 0:
  - CALC occupies cycles 1..32.
  - FIXUP occupies cycle 33.
  - Cycle 34: IDLE, done=1, hilo_q holds the new value.
- Throughput: a new start is accepted in cycle 34 at the earliest. Back-to-back ops are separated by 34 cycles.
- busy is 1 in cycles 1..33 and 0 in cycle 34.
- mthi/mtlo in IDLE: hilo_q updates in the next cycle.
- A combinational mfhi/mflo read is valid in any cycle with busy=0.
- Reset deasserted mid-operation: no partial result is ever written.

## Test plan
- MULTU 0xFFFF_FFFF × 0xFFFF_FFFF, start in cycle 0 -> done in cycle 34, hilo_q = {0xFFFF_FFFE, 0x0000_0001}, busy high for cycles 1..33 exactly.
- MULT −3 × 7, then DIV −7 / 2 on the following start -> {0xFFFF_FFFF, 0xFFFF_FFEB}, then HI=0xFFFF_FFFF (−1), LO=0xFFFF_FFFD (−3).
- DIVU 5 / 0 and DIV 0x8000_0000 / 0xFFFF_FFFF -> {0x0000_0005, 0xFFFF_FFFF}, then {0x0000_0000, 0x8000_0000}. No hang, 34-cycle latency each.
- MULT in flight; assert hilo_rd, then mthi_en with mt_data=0x1234 in cycle 5 -> stall=1 while asserted. HI unaffected until done. mthi retried in cycle 34 -> HI=0x1234 in cycle 35.
- Preload HI/LO = {0xAAAA_AAAA, 0x5555_5555}, start DIVU 100/7, abort in cycle 10; repeat with abort in FIXUP (cycle 33) -> state IDLE next cycle, done never pulses, hilo_q unchanged.
- Start MULTU, pull reset low in cycle 20 -> hilo_q=0, busy=0 immediately. After release, a new MULTU 6×7 completes with {0, 42} in 34 cycles.
